// File: rtl/vuart_mchan.sv
// Multi-channel virtual UART: per channel, a dev->host and a host->dev byte FIFO,
// both reachable from a device APB port and a host APB port on the same clock.

module vuart_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    input  logic       flush,
    output logic [7:0] dout,
    output logic [7:0] level,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr_reg;
    logic [AW-1:0] rptr_reg;
    logic [LW-1:0] count_reg;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_reg == LW'(DEPTH));
    assign empty   = (count_reg == '0);
    // Fullness is judged at the start of the cycle; a flush discards everything.
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign dout    = mem[rptr_reg];
    assign level   = 8'(count_reg);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
        end else if (flush) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push_ok) wptr_reg <= wptr_reg + 1'b1;
            if (pop_ok)  rptr_reg <= rptr_reg + 1'b1;
            count_reg <= count_reg + LW'(push_ok) - LW'(pop_ok);
        end
    end
endmodule

module vuart_mchan #(
    parameter int N_CHAN   = 4,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [N_CHAN-1:0] irq,
    input  logic [N_CHAN-1:0] hostconn,
    input  logic              dev_psel,
    input  logic              dev_penable,
    input  logic              dev_pwrite,
    input  logic [7:0]        dev_paddr,
    input  logic [31:0]       dev_pwdata,
    output logic [31:0]       dev_prdata,
    output logic              dev_pready,
    output logic              dev_pslverr,
    input  logic              host_psel,
    input  logic              host_penable,
    input  logic              host_pwrite,
    input  logic [7:0]        host_paddr,
    input  logic [31:0]       host_pwdata,
    output logic [31:0]       host_prdata,
    output logic              host_pready,
    output logic              host_pslverr
);
    logic       dev_acc, host_acc, dev_ok, host_ok;
    logic [3:0] dev_chan, host_chan;
    logic [1:0] dev_reg, host_reg;
    logic       unused_bits;

    logic [31:0] dev_fifo_word  [N_CHAN];
    logic [31:0] dev_stat_word  [N_CHAN];
    logic [31:0] dev_ctrl_word  [N_CHAN];
    logic [31:0] host_fifo_word [N_CHAN];
    logic [31:0] host_stat_word [N_CHAN];

    assign dev_acc   = dev_psel && dev_penable;
    assign host_acc  = host_psel && host_penable;
    assign dev_chan  = dev_paddr[7:4];
    assign host_chan = host_paddr[7:4];
    assign dev_reg   = dev_paddr[3:2];
    assign host_reg  = host_paddr[3:2];
    assign dev_ok    = ({1'b0, dev_chan} < 5'(N_CHAN));
    assign host_ok   = ({1'b0, host_chan} < 5'(N_CHAN));

    assign dev_pready   = 1'b1;
    assign host_pready  = 1'b1;
    assign dev_pslverr  = dev_psel && !dev_ok;
    assign host_pslverr = host_psel && !host_ok;

    assign unused_bits = ^{dev_paddr[1:0], host_paddr[1:0], dev_pwdata[7:3], host_pwdata[31:8]};

    for (genvar gi = 0; gi < N_CHAN; gi++) begin : g_chan
        logic       dev_hit, host_hit;
        logic       d2h_push, d2h_pop, d2h_flush, h2d_push, h2d_pop, h2d_flush;
        logic [7:0] d2h_dout, h2d_dout, d2h_level, h2d_level;
        logic       d2h_full, d2h_empty, h2d_full, h2d_empty;
        logic       h2d_push_ok, h2d_pop_ok;
        logic       dev_ovf_reg, host_ovf_reg;
        logic [2:0] ie_reg;
        logic [7:0] tx_thresh_reg, rx_thresh_reg, timeout_reg;
        logic [7:0] cnt_reg, cnt_next;
        logic       to_clr, to_flag_reg;
        logic [7:0] rx_thresh_eff;
        logic       irq_reg, irq_next;

        assign dev_hit  = dev_acc && dev_ok && (dev_chan == 4'(gi));
        assign host_hit = host_acc && host_ok && (host_chan == 4'(gi));

        // Each FIFO is the TX side of one port and the RX side of the other.
        assign d2h_push  = dev_hit && dev_pwrite && (dev_reg == 2'd0);
        assign d2h_pop   = host_hit && !host_pwrite && (host_reg == 2'd0);
        assign d2h_flush = (dev_hit && dev_pwrite && (dev_reg == 2'd3) && dev_pwdata[0]) ||
                           (host_hit && host_pwrite && (host_reg == 2'd3) && host_pwdata[1]);
        assign h2d_push  = host_hit && host_pwrite && (host_reg == 2'd0);
        assign h2d_pop   = dev_hit && !dev_pwrite && (dev_reg == 2'd0);
        assign h2d_flush = (dev_hit && dev_pwrite && (dev_reg == 2'd3) && dev_pwdata[1]) ||
                           (host_hit && host_pwrite && (host_reg == 2'd3) && host_pwdata[0]);

        vuart_fifo #(.DEPTH(TX_DEPTH)) u_d2h (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (d2h_push),
            .din   (dev_pwdata[7:0]),
            .pop   (d2h_pop),
            .flush (d2h_flush),
            .dout  (d2h_dout),
            .level (d2h_level),
            .full  (d2h_full),
            .empty (d2h_empty)
        );

        vuart_fifo #(.DEPTH(RX_DEPTH)) u_h2d (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (h2d_push),
            .din   (host_pwdata[7:0]),
            .pop   (h2d_pop),
            .flush (h2d_flush),
            .dout  (h2d_dout),
            .level (h2d_level),
            .full  (h2d_full),
            .empty (h2d_empty)
        );

        assign h2d_push_ok = h2d_push && !h2d_full && !h2d_flush;
        assign h2d_pop_ok  = h2d_pop && !h2d_empty && !h2d_flush;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dev_ovf_reg  <= 1'b0;
                host_ovf_reg <= 1'b0;
            end else begin
                if (d2h_push && d2h_full)
                    dev_ovf_reg <= 1'b1;
                else if (dev_hit && dev_pwrite && (dev_reg == 2'd1) && dev_pwdata[2])
                    dev_ovf_reg <= 1'b0;
                if (h2d_push && h2d_full)
                    host_ovf_reg <= 1'b1;
                else if (host_hit && host_pwrite && (host_reg == 2'd1) && host_pwdata[2])
                    host_ovf_reg <= 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ie_reg        <= '0;
                tx_thresh_reg <= '0;
                rx_thresh_reg <= '0;
                timeout_reg   <= '0;
            end else if (dev_hit && dev_pwrite && (dev_reg == 2'd2)) begin
                ie_reg        <= dev_pwdata[2:0];
                tx_thresh_reg <= dev_pwdata[15:8];
                rx_thresh_reg <= dev_pwdata[23:16];
                timeout_reg   <= dev_pwdata[31:24];
            end
        end

        // Idle counter on the device RX FIFO; any traffic restarts it.
        assign to_clr = h2d_push_ok || h2d_pop_ok || h2d_flush || (timeout_reg == 8'd0);

        always_comb begin
            cnt_next = cnt_reg;
            if (to_clr)
                cnt_next = 8'd0;
            else if (!h2d_empty && (cnt_reg != 8'hFF))
                cnt_next = cnt_reg + 8'd1;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_reg     <= '0;
                to_flag_reg <= 1'b0;
            end else begin
                cnt_reg <= cnt_next;
                if (h2d_pop_ok || h2d_flush || h2d_empty)
                    to_flag_reg <= 1'b0;
                else if (!to_clr && (cnt_next == timeout_reg))
                    to_flag_reg <= 1'b1;
            end
        end

        assign rx_thresh_eff = (rx_thresh_reg == 8'd0) ? 8'd1 : rx_thresh_reg;
        assign irq_next = (ie_reg[0] && (h2d_level >= rx_thresh_eff)) ||
                          (ie_reg[1] && (d2h_level <= tx_thresh_reg)) ||
                          (ie_reg[2] && to_flag_reg);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) irq_reg <= 1'b0;
            else        irq_reg <= irq_next;
        end
        assign irq[gi] = irq_reg;

        assign dev_fifo_word[gi]  = h2d_empty ? 32'd0 : {1'b1, 23'd0, h2d_dout};
        assign dev_stat_word[gi]  = {8'd0, d2h_level, h2d_level, 3'd0, to_flag_reg,
                                     hostconn[gi], dev_ovf_reg, !d2h_full, !h2d_empty};
        assign dev_ctrl_word[gi]  = {timeout_reg, rx_thresh_reg, tx_thresh_reg, 5'd0, ie_reg};
        assign host_fifo_word[gi] = d2h_empty ? 32'd0 : {1'b1, 23'd0, d2h_dout};
        assign host_stat_word[gi] = {8'd0, h2d_level, d2h_level, 5'd0,
                                     host_ovf_reg, !h2d_full, !d2h_empty};
    end

    always_comb begin
        dev_prdata = 32'd0;
        if (dev_psel && dev_ok) begin
            for (int i = 0; i < N_CHAN; i++) begin
                if (dev_chan == 4'(i)) begin
                    case (dev_reg)
                        2'd0:    dev_prdata = dev_fifo_word[i];
                        2'd1:    dev_prdata = dev_stat_word[i];
                        2'd2:    dev_prdata = dev_ctrl_word[i];
                        default: dev_prdata = 32'd0;
                    endcase
                end
            end
        end
    end

    always_comb begin
        host_prdata = 32'd0;
        if (host_psel && host_ok) begin
            for (int i = 0; i < N_CHAN; i++) begin
                if (host_chan == 4'(i)) begin
                    case (host_reg)
                        2'd0:    host_prdata = host_fifo_word[i];
                        2'd1:    host_prdata = host_stat_word[i];
                        default: host_prdata = 32'd0;
                    endcase
                end
            end
        end
    end
endmodule
